// File: rtl/md_pkg.sv
// Shared constants and payload types for the execute-stage multiply/divide unit.
package md_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;
    localparam int unsigned MD_CNT_W           = 4;
    localparam int unsigned MD_DATA_W          = 32;

    typedef struct packed {
        logic [MD_DATA_W-1:0] hi;
        logic [MD_DATA_W-1:0] lo;
    } md_hilo_t;

    function automatic logic md_is_div(input logic [1:0] op, input logic madd);
        return op[1] && !madd;
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational MULT/MULTU/DIV/DIVU/MADD result with a divide-by-zero flag.
module md_calc
    import md_pkg::*;
(
    input  logic [1:0]           i_mdop,
    input  logic                 i_madd,
    input  logic [MD_DATA_W-1:0] i_a,
    input  logic [MD_DATA_W-1:0] i_b,
    input  logic [MD_DATA_W-1:0] i_hi,
    input  logic [MD_DATA_W-1:0] i_lo,
    output md_hilo_t             o_res,
    output logic                 o_dz
);

    logic [63:0]          w_sprod;
    logic [63:0]          w_uprod;
    logic                 w_b_zero;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [MD_DATA_W-1:0] w_a_mag;
    logic [MD_DATA_W-1:0] w_b_mag;
    logic [MD_DATA_W-1:0] w_q_mag;
    logic [MD_DATA_W-1:0] w_r_mag;
    logic [MD_DATA_W-1:0] w_q;
    logic [MD_DATA_W-1:0] w_r;

    assign w_sprod  = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_uprod  = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide runs on magnitudes; a zero divisor is replaced so the divider stays defined.
    assign w_b_zero = (i_b == '0);
    assign w_a_neg  = (i_mdop == MD_DIV) && i_a[31];
    assign w_b_neg  = (i_mdop == MD_DIV) && i_b[31];
    assign w_a_mag  = w_a_neg ? -i_a : i_a;
    assign w_b_mag  = w_b_zero ? MD_DATA_W'(1) : (w_b_neg ? -i_b : i_b);
    assign w_q_mag  = w_a_mag / w_b_mag;
    assign w_r_mag  = w_a_mag % w_b_mag;
    assign w_q      = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    assign w_r      = w_a_neg ? -w_r_mag : w_r_mag;

    always_comb begin
        o_res = '0;
        o_dz  = 1'b0;
        if (i_madd) begin
            o_res = md_hilo_t'({i_hi, i_lo} + w_sprod);
        end else begin
            case (i_mdop)
                MD_MULT:  o_res = md_hilo_t'(w_sprod);
                MD_MULTU: o_res = md_hilo_t'(w_uprod);
                default: begin
                    o_res.hi = w_r;
                    o_res.lo = w_q;
                    o_dz     = w_b_zero;
                end
            endcase
        end
    end

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit owning HI/LO with fixed multi-cycle latency.
// Optional md_cancel input is built in when MD_CANCEL_EN is defined.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdstart,
    input  logic [1:0]  mdop,
    input  logic        isMADD,
    input  logic        mdwrite,
    input  logic        mdHILO,
    input  logic        mdrsel,
    input  logic [31:0] A,
    input  logic [31:0] B,
`ifdef MD_CANCEL_EN
    input  logic        md_cancel,
`endif
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] mdout
);

    localparam logic [MD_CNT_W-1:0] L_MULT_CNT = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] L_DIV_CNT  = MD_CNT_W'(DIV_CYCLES);

    logic                 r_busy,     w_busy_nxt;
    logic [MD_CNT_W-1:0]  r_cnt,      w_cnt_nxt;
    logic [MD_DATA_W-1:0] r_hi,       w_hi_nxt;
    logic [MD_DATA_W-1:0] r_lo,       w_lo_nxt;
    md_hilo_t             r_pend,     w_pend_nxt;
    logic                 r_pend_dz,  w_pend_dz_nxt;

    md_hilo_t             w_calc;
    logic                 w_calc_dz;
    logic                 w_cancel;
    logic                 w_start;
    logic                 w_write;

`ifdef MD_CANCEL_EN
    assign w_cancel = md_cancel;
`else
    assign w_cancel = 1'b0;
`endif

    // Start beats write; both are dropped while an operation is in flight.
    assign w_start = mdstart && !r_busy && !w_cancel;
    assign w_write = mdwrite && !mdstart && !r_busy && !w_cancel;

    md_calc u_calc (
        .i_mdop (mdop),
        .i_madd (isMADD),
        .i_a    (A),
        .i_b    (B),
        .i_hi   (r_hi),
        .i_lo   (r_lo),
        .o_res  (w_calc),
        .o_dz   (w_calc_dz)
    );

    always_comb begin
        w_busy_nxt    = r_busy;
        w_cnt_nxt     = r_cnt;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_nxt    = r_pend;
        w_pend_dz_nxt = r_pend_dz;
        if (w_start) begin
            w_busy_nxt    = 1'b1;
            w_cnt_nxt     = md_is_div(mdop, isMADD) ? L_DIV_CNT : L_MULT_CNT;
            w_pend_nxt    = w_calc;
            w_pend_dz_nxt = w_calc_dz;
        end else if (r_busy) begin
            // Last busy cycle commits the captured result unless it was a divide by zero.
            if (r_cnt == MD_CNT_W'(1)) begin
                w_busy_nxt = 1'b0;
                w_cnt_nxt  = '0;
                if (!r_pend_dz) begin
                    w_hi_nxt = r_pend.hi;
                    w_lo_nxt = r_pend.lo;
                end
            end else begin
                w_cnt_nxt = r_cnt - MD_CNT_W'(1);
            end
        end else if (w_write) begin
            if (mdHILO) w_hi_nxt = A;
            else        w_lo_nxt = A;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend    <= '0;
            r_pend_dz <= 1'b0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend    <= w_pend_nxt;
            r_pend_dz <= w_pend_dz_nxt;
        end
    end

    assign busy      = r_busy;
    assign stall_req = mdstart | r_busy;
    assign mdout     = mdrsel ? r_hi : r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed table, corner sequences and randomized ops vs. a model.
module tb_md_unit;

    logic        clk;
    logic        rst_n;
    logic        mdstart;
    logic [1:0]  mdop;
    logic        isMADD;
    logic        mdwrite;
    logic        mdHILO;
    logic        mdrsel;
    logic [31:0] A;
    logic [31:0] B;
`ifdef MD_CANCEL_EN
    logic        md_cancel;
`endif
    logic        busy;
    logic        stall_req;
    logic [31:0] mdout;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    md_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mdstart   (mdstart),
        .mdop      (mdop),
        .isMADD    (isMADD),
        .mdwrite   (mdwrite),
        .mdHILO    (mdHILO),
        .mdrsel    (mdrsel),
        .A         (A),
        .B         (B),
`ifdef MD_CANCEL_EN
        .md_cancel (md_cancel),
`endif
        .busy      (busy),
        .stall_req (stall_req),
        .mdout     (mdout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        assert (!(rst_n && busy && mdstart))
            else $error("FAIL start_while_busy: mdstart=%0b busy=%0b", mdstart, busy);
    end

    typedef struct {
        logic [1:0]  op;
        logic        madd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cyc;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic logic [64:0] model(input logic [1:0] op, input logic madd,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hi, input logic [31:0] lo);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        if (madd) begin
            p = {hi, lo} + sa * sb;
            return {1'b0, p};
        end
        case (op)
            2'd0: begin p = sa * sb; return {1'b0, p}; end
            2'd1: begin p = ua * ub; return {1'b0, p}; end
            2'd2: begin
                if (b == 0) return {1'b1, hi, lo};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {1'b1, hi, lo};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    task automatic wr(input logic hilo, input logic [31:0] val);
        mdwrite = 1'b1;
        mdHILO  = hilo;
        A       = val;
        tick();
        mdwrite = 1'b0;
        if (hilo) m_hi = val;
        else      m_lo = val;
    endtask

    task automatic wait_idle(input string nm, input int exp_cyc);
        int n;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        chk({nm, "_busy_cycles"}, 32'(n), 32'(exp_cyc));
    endtask

    task automatic chk_hilo(input string nm, input logic [31:0] ehi, input logic [31:0] elo);
        mdrsel = 1'b1;
        #1;
        chk({nm, "_hi"}, mdout, ehi);
        mdrsel = 1'b0;
        #1;
        chk({nm, "_lo"}, mdout, elo);
        m_hi = ehi;
        m_lo = elo;
    endtask

    task automatic run_op(input logic [1:0] op, input logic madd, input logic [31:0] a,
                          input logic [31:0] b, input int cyc, input logic [31:0] ehi,
                          input logic [31:0] elo, input string nm);
        mdstart = 1'b1;
        mdop    = op;
        isMADD  = madd;
        A       = a;
        B       = b;
        mdrsel  = 1'b0;
        #1;
        chk({nm, "_stall_on_start"}, 32'(stall_req), 32'd1);
        tick();
        mdstart = 1'b0;
        isMADD  = 1'b0;
        chk({nm, "_old_lo_while_busy"}, mdout, m_lo);
        wait_idle(nm, cyc);
        chk_hilo(nm, ehi, elo);
    endtask

    initial begin
        logic [64:0] exp;
        logic [1:0]  op;
        logic        madd;
        logic [31:0] a, b;
        int          cyc;

        tbl[0] = '{2'd0, 1'b0, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        tbl[1] = '{2'd1, 1'b0, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0, 32'h00000002, 32'hFFFFFFFA, 5};
        tbl[2] = '{2'd2, 1'b0, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        tbl[3] = '{2'd3, 1'b0, 32'd7, 32'd2, 32'h0, 32'h0, 32'd1, 32'd3, 10};
        tbl[4] = '{2'd3, 1'b1, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 32'd1, 32'd0, 5};
        tbl[5] = '{2'd2, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h1, 32'h1, 32'd0, 32'h80000000, 10};
        tbl[6] = '{2'd2, 1'b0, 32'd99, 32'd0, 32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 10};
        tbl[7] = '{2'd3, 1'b0, 32'd99, 32'd0, 32'hCAFEF00D, 32'h0BADBEEF, 32'hCAFEF00D, 32'h0BADBEEF, 10};
        tbl[8] = '{2'd0, 1'b1, 32'hFFFFFFFF, 32'd3, 32'h0, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        tbl[9] = '{2'd2, 1'b0, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0, 32'd1, 32'hFFFFFFFD, 10};

        rst_n = 1'b0; mdstart = 1'b0; mdop = 2'd0; isMADD = 1'b0; mdwrite = 1'b0;
        mdHILO = 1'b0; mdrsel = 1'b0; A = '0; B = '0;
`ifdef MD_CANCEL_EN
        md_cancel = 1'b0;
`endif
        #2;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_stall_idle", 32'(stall_req), 32'd0);
        chk("reset_lo", mdout, 32'd0);
        mdrsel = 1'b1;
        #1;
        chk("reset_hi", mdout, 32'd0);
        mdstart = 1'b1;
        #1;
        chk("reset_stall_follows_start", 32'(stall_req), 32'd1);
        mdstart = 1'b0;
        mdrsel  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            wr(1'b1, tbl[i].pre_hi);
            wr(1'b0, tbl[i].pre_lo);
            run_op(tbl[i].op, tbl[i].madd, tbl[i].a, tbl[i].b, tbl[i].cyc,
                   tbl[i].exp_hi, tbl[i].exp_lo, $sformatf("tbl%0d", i));
        end

        // MTHI issued while busy must be dropped.
        wr(1'b1, 32'd0);
        wr(1'b0, 32'h10);
        mdstart = 1'b1; mdop = 2'd0; A = 32'd3; B = 32'd4;
        tick();
        mdstart = 1'b0; mdwrite = 1'b1; mdHILO = 1'b1; A = 32'hDEADBEEF;
        tick();
        mdwrite = 1'b0; mdrsel = 1'b1;
        #1;
        chk("mthi_busy_hi_hold", mdout, 32'd0);
        mdrsel = 1'b0;
        wait_idle("mthi_busy", 4);
        chk_hilo("mthi_busy", 32'd0, 32'd12);

        // Start and write in the same cycle: write is lost.
        wr(1'b0, 32'h55);
        mdstart = 1'b1; mdop = 2'd1; A = 32'd2; B = 32'd3;
        mdwrite = 1'b1; mdHILO = 1'b0;
        tick();
        mdstart = 1'b0; mdwrite = 1'b0;
        chk("start_wr_lo_hold", mdout, 32'h55);
        wait_idle("start_wr", 5);
        chk_hilo("start_wr", 32'd0, 32'd6);

`ifdef MD_CANCEL_EN
        mdstart = 1'b1; md_cancel = 1'b1; mdop = 2'd0; A = 32'd9; B = 32'd9;
        tick();
        mdstart = 1'b0;
        chk("cancel_start_busy", 32'(busy), 32'd0);
        mdwrite = 1'b1; mdHILO = 1'b1; A = 32'h777;
        tick();
        mdwrite = 1'b0; md_cancel = 1'b0;
        chk_hilo("cancel", 32'd0, 32'd6);
        mdstart = 1'b1; mdop = 2'd1; A = 32'd5; B = 32'd5;
        tick();
        mdstart = 1'b0; md_cancel = 1'b1;
        wait_idle("cancel_inflight", 4);
        md_cancel = 1'b0;
        chk_hilo("cancel_inflight", 32'd0, 32'd25);
`endif

        // Randomized operations against the model.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) wr(1'($urandom_range(0, 1)), $urandom);
            op   = 2'($urandom_range(0, 3));
            madd = ($urandom_range(0, 4) == 0);
            a    = $urandom;
            b    = $urandom;
            if (op[1] && !madd) begin
                case ($urandom_range(0, 3))
                    0: b = 32'd0;
                    1: b = 32'($urandom_range(1, 9));
                    2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                    default: ;
                endcase
            end
            cyc = (op[1] && !madd) ? 10 : 5;
            exp = model(op, madd, a, b, m_hi, m_lo);
            run_op(op, madd, a, b, cyc, exp[63:32], exp[31:0], $sformatf("rnd%0d", i));
        end

        // Reset in the third busy cycle of a MULT aborts with no later commit.
        wr(1'b1, 32'hA5A5);
        wr(1'b0, 32'h5A5A);
        mdstart = 1'b1; mdop = 2'd0; A = 32'd5; B = 32'd5;
        tick();
        mdstart = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_stall", 32'(stall_req), 32'd0);
        chk_hilo("rst_mid", 32'd0, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("rst_after_busy", 32'(busy), 32'd0);
        chk_hilo("rst_after", 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Execute-stage multiply/divide responder. Consumes the md control bundle that the ID/EX pipeline register delivers (mdstartE, mdwriteE, mdHILOE, mdopE, mdrselE, isMADDE) plus forwarded operands.
- Owns the architectural HI/LO registers and models fixed multi-cycle latency.
- Drives busy/stall information back to the hazard unit and the read data to the E-stage result mux (MFHI/MFLO).

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU/MADD after the start cycle (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU after the start cycle (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- mdstart  in  1  start an operation this cycle
- mdop  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- isMADD  in  1  with mdstart: signed multiply-accumulate into {HI,LO}; mdop ignored
- mdwrite  in  1  MTHI/MTLO write this cycle
- mdHILO  in  1  write target: 1 HI, 0 LO
- mdrsel  in  1  read select: 1 HI, 0 LO
- A  in  32  operand rs (forwarded)
- B  in  32  operand rt (forwarded)
- busy  out  1  registered, operation in flight
- stall_req  out  1  mdstart | busy (combinational), used by the hazard unit
- mdout  out  32  mdrsel ? HI : LO (combinational from registers)

Behaviour:
- Reset (async, rst_n=0): HI=0, LO=0, busy=0, counter=0, pending result=0. mdout=0, stall_req=mdstart.
- Start (mdstart=1, busy=0): capture result at the clock edge into the pending register.
  - MULT: signed 64-bit A*B.
  - MULTU: unsigned 64-bit A*B.
  - DIV: LO=signed quotient, HI=signed remainder (truncate toward zero; remainder takes the sign of the dividend).
  - DIVU: unsigned quotient and remainder.
  - MADD: {HI,LO} + signed A*B, mod 2^64, using HI/LO values at the start edge.
  - busy<=1; counter<=MULT_CYCLES or DIV_CYCLES.
- While busy: counter decrements each cycle. In the cycle counter==1, HI/LO<=pending and busy<=0.
  - Net effect: busy is high for exactly N cycles, and new HI/LO are visible on mdout in the cycle after busy falls.
- Divide by zero (DIV/DIVU with B=0): busy sequence runs normally; HI/LO unchanged at completion.
- mdstart while busy=1: ignored. The hazard unit guarantees this does not occur; the bench asserts it.
- mdwrite while busy=0: target register <= A at the edge. Ignored while busy=1.
- mdstart and mdwrite in the same cycle: mdstart wins, mdwrite dropped.
- mdout during busy returns the old HI/LO. The hazard unit stalls MFHI/MFLO via stall_req.
- DIV overflow (0x80000000 / -1): LO=0x80000000, HI=0.
- Reset asserted mid-operation: abort immediately, all state returns to reset values, no commit.

Optional Feature:
- Macro: MD_CANCEL_EN.
- Enabled: adds input port md_cancel (1 bit), driven by the exception/interrupt logic.
  - md_cancel=1 in the same cycle as mdstart or mdwrite suppresses that start/write: no state change, busy stays 0.
  - An operation already in flight is unaffected and commits normally.
- Disabled: port absent; every mdstart/mdwrite is accepted per the rules above.

Decomposition:
- Package md_pkg:
  - opcode constants MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11
  - default latencies MD_MULT_CYCLES_DEF=5, MD_DIV_CYCLES_DEF=10
  - counter width constant MD_CNT_W=4
- Sub-module md_calc: purely combinational 64-bit result from (mdop, isMADD, A, B, HI, LO) plus a div-by-zero flag. md_unit keeps the counter, busy, pending and HI/LO registers.

Test Plan:
- MULT, A=0xFFFFFFFE, B=3 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; mdout follows mdrsel.
- MULTU, same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV, A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU, A=7, B=2 -> LO=3, HI=1.
- MADD and MTHI/MTLO:
  - MTLO A=0xFFFFFFFF, then MTHI A=0.
  - MADD A=1, B=1 -> HI=1, LO=0.
  - MTHI during busy ignored.
  - DIV with B=0 leaves HI/LO unchanged.
- Reset and cancel:
  - rst_n low at cycle 3 of a MULT -> busy=0, HI=LO=0 immediately; no later commit.
  - With MD_CANCEL_EN: md_cancel together with mdstart -> busy stays 0, HI/LO unchanged.
